// File: rtl/alu_divisor_seq_if.sv
// ---------------------------------------------------------------------------
// alu_divisor_seq_if
//   Bundle of the request/result signals of the sequential divider.
//
//   Handshake: the master raises start with A/B stable.  The divider samples
//   start only in IDLE or DONE, and captures A/B on that same edge.  done is
//   a one-cycle pulse.  Q/R/div_zero become valid in the done cycle and hold
//   until the next done.  start seen during CALC is ignored.
//
//   Ports (master side view)
//     start      out  1      request
//     A, B       out  WIDTH  dividend / divisor
//     busy       in   1      high while iterating
//     done       in   1      result-valid pulse
//     Q, R       in   WIDTH  quotient / remainder
//     div_zero   in   1      captured divisor was zero
//     state_dbg  in   2      current FSM state, for observation
// ---------------------------------------------------------------------------
interface alu_divisor_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             div_zero;
    logic [1:0]       state_dbg;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, div_zero, state_dbg
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, div_zero, state_dbg
    );
endinterface

// File: rtl/alu_divisor_seq.sv
// ---------------------------------------------------------------------------
// alu_divisor_seq
//   Unsigned restoring divider, one quotient bit per clock.
//   Computes Q = A / B and R = A % B in WIDTH cycles after the accepting
//   edge.  A zero divisor short-circuits to DONE with Q = all ones, R = A
//   and div_zero = 1.
//
//   Ports
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset; aborts any operation
//     bus    alu_divisor_seq_if.slave (start, A, B, busy, done, Q, R,
//            div_zero, state_dbg)
// ---------------------------------------------------------------------------
module alu_divisor_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_divisor_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] div;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dz_r;

    // Trial subtraction on the shifted partial remainder.  The top bit of the
    // shifted value is kept so the subtraction is exact at WIDTH+1 bits.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;

    assign shifted   = {rem, quot[WIDTH-1]};
    assign trial     = shifted - {1'b0, div};
    assign rem_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_step = {quot[WIDTH-2:0], ~trial[WIDTH]};

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (bus.B == '0) ? S_DONE : S_CALC;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (count == CW'(1)) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quot  <= '0;
            div   <= '0;
            count <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dz_r  <= 1'b0;
        end else if (accept) begin
            if (bus.B == '0) begin
                q_r  <= '1;
                r_r  <= bus.A;
                dz_r <= 1'b1;
            end else begin
                div   <= bus.B;
                quot  <= bus.A;
                rem   <= '0;
                count <= CW'(WIDTH);
            end
        end else if (state == S_CALC) begin
            rem   <= rem_step;
            quot  <= quot_step;
            count <= count - CW'(1);
            // Last iteration: publish this step's values directly.
            if (count == CW'(1)) begin
                q_r  <= quot_step;
                r_r  <= rem_step;
                dz_r <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state == S_CALC);
    assign bus.done      = (state == S_DONE);
    assign bus.Q         = q_r;
    assign bus.R         = r_r;
    assign bus.div_zero  = dz_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_alu_divisor_seq.sv
module tb_alu_divisor_seq;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    alu_divisor_seq_if #(.WIDTH(W)) dif ();

    alu_divisor_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W:0] exp_q[$];   // {div_zero, Q, R}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the definition of division.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) return {1'b1, {W{1'b1}}, a};
        q = W'(int'(a) / int'(b));
        r = W'(int'(a) % int'(b));
        return {1'b0, q, r};
    endfunction

    // ---------------- driver ----------------
    // lat = edges after the accepting edge before done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat,
                          output bit busy_seen, output logic busy_at_done);
        @(negedge clk);
        dif.A = a;
        dif.B = b;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        lat = 0;
        busy_seen = 1'b0;
        while (dif.done !== 1'b1 && lat < 20) begin
            if (dif.busy === 1'b1) busy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        q = dif.Q;
        r = dif.R;
        dz = dif.div_zero;
        busy_at_done = dif.busy;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [W-1:0] q, r;
        logic dz, bad;
        logic [2*W:0] e;
        int lat;
        bit bs;

        vecs[0] = '{a:13, b:4,  q:3,  r:1, dz:0};
        vecs[1] = '{a:15, b:1,  q:15, r:0, dz:0};
        vecs[2] = '{a:5,  b:7,  q:0,  r:5, dz:0};
        vecs[3] = '{a:9,  b:9,  q:1,  r:0, dz:0};
        vecs[4] = '{a:9,  b:0,  q:15, r:9, dz:1};
        vecs[5] = '{a:0,  b:5,  q:0,  r:0, dz:0};
        vecs[6] = '{a:0,  b:0,  q:15, r:0, dz:1};
        vecs[7] = '{a:15, b:15, q:1,  r:0, dz:0};
        vecs[8] = '{a:1,  b:15, q:0,  r:1, dz:0};
        vecs[9] = '{a:14, b:3,  q:4,  r:2, dz:0};

        rst_n = 1'b0;
        dif.start = 1'b0;
        dif.A = '0;
        dif.B = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", dif.busy, 0);
        check("reset_done", dif.done, 0);
        check("reset_q", dif.Q, 0);
        check("reset_r", dif.R, 0);
        check("reset_dz", dif.div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table vectors ----
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dz, lat, bs, bad);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
            check($sformatf("vec%0d_lat", i), lat, (vecs[i].b == 0) ? 0 : W);
            check($sformatf("vec%0d_busy_seen", i), bs, (vecs[i].b != 0));
            check($sformatf("vec%0d_busy_at_done", i), bad, 0);
        end

        // ---- done is a single pulse and results hold ----
        run_op(4'd13, 4'd4, q, r, dz, lat, bs, bad);
        @(negedge clk);
        check("pulse_done_low", dif.done, 0);
        repeat (3) @(negedge clk);
        check("hold_q", dif.Q, 3);
        check("hold_r", dif.R, 1);
        check("hold_dz", dif.div_zero, 0);

        // ---- start held during CALC with new operands is ignored ----
        @(negedge clk);
        dif.A = 4'd13;
        dif.B = 4'd4;
        dif.start = 1'b1;
        @(negedge clk);
        dif.A = 4'd2;
        dif.B = 4'd1;
        lat = 0;
        while (dif.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dif.start = 1'b0;
        check("ignore_lat", lat, W);
        check("ignore_q", dif.Q, 3);
        check("ignore_r", dif.R, 1);
        @(negedge clk);
        check("ignore_idle_busy", dif.busy, 0);
        check("ignore_idle_done", dif.done, 0);

        // ---- reset in the middle of an operation ----
        run_op(4'd15, 4'd2, q, r, dz, lat, bs, bad);
        check("pre_reset_q", q, 7);
        @(negedge clk);
        dif.A = 4'd14;
        dif.B = 4'd3;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", dif.busy, 0);
        check("abort_done", dif.done, 0);
        check("abort_q", dif.Q, 0);
        check("abort_r", dif.R, 0);
        check("abort_dz", dif.div_zero, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", dif.done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_abort_no_done", dif.done, 0);
        end
        run_op(4'd14, 4'd3, q, r, dz, lat, bs, bad);
        check("post_reset_q", q, 4);
        check("post_reset_r", r, 2);
        check("post_reset_lat", lat, W);

        // ---- randomized operations against the reference model ----
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 15));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 15));
            exp_q.push_back(model(ra, rb));
            run_op(ra, rb, q, r, dz, lat, bs, bad);
            e = exp_q.pop_front();
            check($sformatf("rand%0d_q(%0d/%0d)", i, ra, rb), q, e[2*W-1:W]);
            check($sformatf("rand%0d_r(%0d/%0d)", i, ra, rb), r, e[W-1:0]);
            check($sformatf("rand%0d_dz", i), dz, e[2*W]);
            check($sformatf("rand%0d_lat", i), lat, (rb == 0) ? 0 : W);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // ---- exhaustive back-to-back sweep: start re-asserted in DONE ----
        begin
            int idx;
            int gap;
            logic [W-1:0] cb;
            idx = 0;
            @(negedge clk);
            cb = '0;
            dif.A = '0;
            dif.B = '0;
            dif.start = 1'b1;
            exp_q.push_back(model('0, '0));
            gap = 0;
            while (idx < 256) begin
                @(negedge clk);
                gap++;
                if (dif.done === 1'b1) begin
                    e = exp_q.pop_front();
                    check($sformatf("sweep%0d_q", idx), dif.Q, e[2*W-1:W]);
                    check($sformatf("sweep%0d_r", idx), dif.R, e[W-1:0]);
                    check($sformatf("sweep%0d_dz", idx), dif.div_zero, e[2*W]);
                    check($sformatf("sweep%0d_gap", idx), gap, (cb == 0) ? 1 : W + 1);
                    idx++;
                    if (idx < 256) begin
                        dif.A = W'(idx >> W);
                        dif.B = W'(idx);
                        cb = W'(idx);
                        exp_q.push_back(model(W'(idx >> W), W'(idx)));
                    end
                    gap = 0;
                end else if (gap > 20) begin
                    check($sformatf("sweep%0d_timeout", idx), gap, W + 1);
                    break;
                end
            end
            dif.start = 1'b0;
            @(negedge clk);
            check("sweep_end_idle", dif.busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
